// File: rtl/exec_unit_if.sv
// Execute-stage handshake and operand/result bundle between the control path
// (master) and the execute unit (slave).
interface exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUOperation;
  logic [5:0]       instFunc;
  logic             rType;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, ALUOperation, instFunc, rType, opA, opB,
    input  result, zero, busy, done, hi, lo
  );

  modport slave (
    input  start, ALUOperation, instFunc, rType, opA, opB,
    output result, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/exec_unit.sv
// Execute unit: single-cycle ALU ops, MFHI/MFLO, and an iterative signed shift-add MULT into HI/LO.
// Optional macro EXEC_UNIT_MULTU_EN adds unsigned MULTU (funct 011001) on the same multiply FSM.
module exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  exec_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, SIGN} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               zero_reg, zero_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               neg_reg, neg_next;

  logic               accept, is_mult, is_multu, is_mfhi, is_mflo, slt;
  logic [WIDTH-1:0]   and_v, or_v, xor_v, alu_res, sel_res, abs_a, abs_b;

  assign accept  = bus.start && (state_reg == IDLE);
  assign is_mult = bus.rType && (bus.instFunc == 6'b011000);
  assign is_mfhi = bus.rType && (bus.instFunc == 6'b010000);
  assign is_mflo = bus.rType && (bus.instFunc == 6'b010010);
`ifdef EXEC_UNIT_MULTU_EN
  assign is_multu = bus.rType && (bus.instFunc == 6'b011001);
`else
  assign is_multu = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign and_v[gi] = bus.opA[gi] & bus.opB[gi];
      assign or_v[gi]  = bus.opA[gi] | bus.opB[gi];
      assign xor_v[gi] = bus.opA[gi] ^ bus.opB[gi];
    end
  endgenerate

  assign slt = $signed(bus.opA) < $signed(bus.opB);

  // The most negative input negates to itself, which read unsigned is exactly 2^(WIDTH-1).
  assign abs_a = bus.opA[WIDTH-1] ? (~bus.opA + WIDTH'(1)) : bus.opA;
  assign abs_b = bus.opB[WIDTH-1] ? (~bus.opB + WIDTH'(1)) : bus.opB;

  always_comb begin
    alu_res = '0;
    case (bus.ALUOperation)
      3'b000:  alu_res = and_v;
      3'b001:  alu_res = or_v;
      3'b011:  alu_res = xor_v;
      3'b010:  alu_res = bus.opA + bus.opB;
      3'b110:  alu_res = bus.opA - bus.opB;
      3'b111:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    sel_res = alu_res;
    if (is_mfhi)
      sel_res = hi_reg;
    else if (is_mflo)
      sel_res = lo_reg;
  end

  always_comb begin
    state_next  = state_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    mplier_next = mplier_reg;
    mcand_next  = mcand_reg;
    prod_next   = prod_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    neg_next    = neg_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_mult || is_multu) begin
            mcand_next  = {{WIDTH{1'b0}}, (is_multu ? bus.opA : abs_a)};
            mplier_next = is_multu ? bus.opB : abs_b;
            neg_next    = is_multu ? 1'b0 : (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
            prod_next   = '0;
            cnt_next    = '0;
            busy_next   = 1'b1;
            state_next  = MUL;
          end else begin
            result_next = sel_res;
            zero_next   = (sel_res == '0);
            done_next   = 1'b1;
          end
        end
      end
      MUL: begin
        if (mplier_reg[0])
          prod_next = prod_reg + mcand_reg;
        mcand_next  = {mcand_reg[2*WIDTH-2:0], 1'b0};
        mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
        cnt_next    = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH-1))
          state_next = SIGN;
      end
      SIGN: begin
        {hi_next, lo_next} = neg_reg ? (~prod_reg + (2*WIDTH)'(1)) : prod_reg;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mplier_reg <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      mplier_reg <= mplier_next;
      mcand_reg  <= mcand_next;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      neg_reg    <= neg_next;
    end
  end

  assign bus.result = result_reg;
  assign bus.zero   = zero_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.hi     = hi_reg;
  assign bus.lo     = lo_reg;
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: driver pushes expected responses, a monitor pops on every done.
module tb_exec_unit;
  localparam int W = 32;
`ifdef EXEC_UNIT_MULTU_EN
  localparam bit MULTU = 1'b1;
`else
  localparam bit MULTU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_unit_if #(.WIDTH(W)) bus ();
  exec_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string        name;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_result = '0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=1 required=0");
      end else begin
        e = q.pop_front();
        $display("txn %s result=%h zero=%b hi=%h lo=%h", e.name, bus.result, bus.zero, bus.hi, bus.lo);
        chk({e.name, "_result"}, 64'(bus.result), 64'(e.result));
        chk({e.name, "_zero"}, 64'(bus.zero), 64'(e.zero));
        chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_result"}, 64'(bus.result), 64'd0);
    chk({tag, "_zero"}, 64'(bus.zero), 64'd1);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'd0);
    chk({tag, "_lo"}, 64'(bus.lo), 64'd0);
  endtask

  // Called aligned to a negedge; returns aligned to a negedge so ops chain back-to-back.
  task automatic do_op(input string name, input logic [2:0] alu, input logic [5:0] func,
                       input logic rt, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inject = 0, input int abort = 0);
    exp_t        e;
    bit          mul;
    logic [63:0] pv;
    int          n;
    mul = rt && (func == 6'b011000 || (MULTU && func == 6'b011001));
    bus.start = 1'b1;
    bus.ALUOperation = alu;
    bus.instFunc = func;
    bus.rType = rt;
    bus.opA = a;
    bus.opB = b;
    if (mul) begin
      if (func == 6'b011000)
        pv = longint'($signed(a)) * longint'($signed(b));
      else
        pv = {32'b0, a} * {32'b0, b};
      m_hi = pv[63:32];
      m_lo = pv[31:0];
    end else if (rt && func == 6'b010000) begin
      m_result = m_hi;
    end else if (rt && func == 6'b010010) begin
      m_result = m_lo;
    end else begin
      case (alu)
        3'b000:  m_result = a & b;
        3'b001:  m_result = a | b;
        3'b011:  m_result = a ^ b;
        3'b010:  m_result = a + b;
        3'b110:  m_result = a - b;
        3'b111:  m_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: m_result = '0;
      endcase
    end
    e.name = name;
    e.result = m_result;
    e.zero = (m_result == '0);
    e.hi = m_hi;
    e.lo = m_lo;
    q.push_back(e);
    if (!mul) begin
      @(negedge clk);
      return;
    end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (!bus.busy) break;
      n++;
      if (n == inject) begin
        bus.start = 1'b1;
        bus.ALUOperation = 3'b010;
        bus.rType = 1'b0;
        bus.opA = 32'd1;
        bus.opB = 32'd1;
      end
      if (n == abort) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs({name, "_abort"});
        q.delete();
        m_result = '0;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(W + 1));
  endtask

  task automatic idle(input int cycles);
    bus.start = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [5:0] f;
    bus.start = 1'b0;
    bus.ALUOperation = 3'b000;
    bus.instFunc = 6'b0;
    bus.rType = 1'b0;
    bus.opA = '0;
    bus.opB = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    idle(2);

    do_op("add_ovf", 3'b010, 6'h00, 1'b0, 32'h7FFF_FFFF, 32'd1);
    do_op("sub_zero", 3'b110, 6'h00, 1'b0, 32'd5, 32'd5);
    idle(1);
    do_op("slt_neg", 3'b111, 6'h00, 1'b0, 32'hFFFF_FFFF, 32'd1);
    do_op("slt_swap", 3'b111, 6'h00, 1'b0, 32'd1, 32'hFFFF_FFFF);
    do_op("and", 3'b000, 6'h00, 1'b0, 32'hF0F0_1234, 32'hFF00_FFFF);
    do_op("undef", 3'b100, 6'h00, 1'b0, 32'h1234_5678, 32'h1);
    do_op("mult_m3x7", 3'b010, 6'b011000, 1'b1, 32'hFFFF_FFFD, 32'd7);
    do_op("mult_min", 3'b010, 6'b011000, 1'b1, 32'h8000_0000, 32'h8000_0000);
    do_op("mfhi", 3'b000, 6'b010000, 1'b1, 32'h0, 32'h0);
    do_op("mflo", 3'b000, 6'b010010, 1'b1, 32'h0, 32'h0);
    idle(1);
    do_op("add_pre", 3'b010, 6'h00, 1'b0, 32'd3, 32'd4);
    do_op("mult_inj", 3'b010, 6'b011000, 1'b1, 32'd11, 32'hFFFF_FFF0, 5);
    do_op("mult_abort", 3'b010, 6'b011000, 1'b1, 32'd9, 32'd9, 0, 10);
    idle(2);
    do_op("mult_6x7", 3'b010, 6'b011000, 1'b1, 32'd6, 32'd7);
    do_op("multu_fn", 3'b010, 6'b011001, 1'b1, 32'hFFFF_FFFF, 32'd2);
    do_op("mfhi2", 3'b000, 6'b010000, 1'b1, 32'h0, 32'h0);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    f = 6'b011000;
        2:       f = 6'b010000;
        3:       f = 6'b010010;
        4:       f = 6'b011001;
        default: f = 6'($urandom_range(0, 63));
      endcase
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), f, 1'($urandom_range(0, 1)),
            pick(), pick());
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    idle(4);
    chk("pending", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute-stage datapath block that consumes the 3-bit ALU operation code and the 6-bit function field produced by the ALU control decoder.
- Performs single-cycle logic/arithmetic ops with a registered result.
- Runs MULT as an iterative signed shift-add over multiple cycles into HI/LO registers, and serves MFHI/MFLO from those registers.
- Sits between the register file read ports and the writeback mux; handshakes with the control path through start, busy and done.

Parameters:
WIDTH, 32, operand/result width; multiply iteration count equals WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  operation presented this cycle
ALUOperation  input  3  op code: 000 AND, 001 OR, 011 XOR, 010 ADD, 110 SUB, 111 SLT
instFunc  input  6  R-type function field
rType  input  1  high when instFunc is meaningful (ALUOp==2'b10)
opA  input  WIDTH  operand A (rs)
opB  input  WIDTH  operand B (rt or immediate)
result  output  WIDTH  registered result
zero  output  1  registered (result==0)
busy  output  1  multiply in progress
done  output  1  one-cycle completion pulse
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst low, asynchronous, any state including mid-multiply):
  - state=IDLE, result=0, zero=1, busy=0, done=0, hi=0, lo=0, iteration counter=0.
  - An in-flight multiply is discarded.
- Accept rule: start is accepted only on an edge where state==IDLE. start while busy is ignored and has no side effects.
- Decode priority on accept:
  - rType && instFunc==011000 (MULT): multiply.
  - rType && instFunc==010000 (MFHI) / 010010 (MFLO): read HI/LO.
  - Otherwise: ALU op selected by ALUOperation.
- Single-cycle ops (accept edge E0):
  - result, zero and done=1 update at E0; busy stays 0; done clears at E1 unless another op is accepted.
  - ADD/SUB: modulo 2^WIDTH; carry/overflow dropped.
  - SLT: signed compare, result = {0..0, (A<B)}.
  - MFHI/MFLO: result=hi/lo.
  - Undefined codes (100, 101): result=0, zero=1, done pulses.
- MULT FSM, states IDLE -> MUL -> SIGN -> IDLE:
  - E0 (accept):
    - Latch |opA| into the multiplicand and |opB| into the multiplier.
    - Latch neg = opA[W-1]^opB[W-1].
    - Clear the 2W-bit product; counter=0; busy=1; state=MUL.
  - MUL: each edge adds the shifted multiplicand if the current multiplier bit is 1, shifts, counter++. After exactly WIDTH MUL edges (E1..EW), state=SIGN.
  - SIGN, edge E(W+1):
    - {hi,lo} = neg ? two's-complement(product) : product.
    - busy=0, done=1, state=IDLE.
  - result and zero are unchanged by MULT.
  - busy is high for exactly WIDTH+1 cycles after accept.
  - A new start can be accepted at E(W+1)+1.
  - Absolute value of the most negative input (0x80000000) is taken as the unsigned 2^(W-1); the product must be correct.
- HI/LO hold their value until the next MULT completes; they are not writable otherwise.
- Back-to-back single-cycle ops: one accepted per cycle, with done held high continuously.

Optional Feature:
- Macro: EXEC_UNIT_MULTU_EN.
- Defined: rType && instFunc==011001 (MULTU) uses the same FSM with no absolute-value conversion and neg forced to 0, giving an unsigned 2W-bit product into {hi,lo} with identical latency.
- Undefined: 011001 decodes as an ordinary ALU op per ALUOperation; HI/LO are untouched.

Test Plan:
- ADD 0x7FFFFFFF + 1, then SUB 5-5 back-to-back -> result 0x80000000 with zero=0, then 0 with zero=1; done high two consecutive cycles.
- SLT opA=0xFFFFFFFF (-1), opB=1 -> result 1; with operands swapped -> result 0.
- MULT opA=-3, opB=7 -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; result unchanged.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0; then MFHI -> result 0x40000000 next edge; MFLO -> result 0, zero=1.
- start asserted with an ADD during busy -> ignored, no done; rst pulsed low at cycle 10 of a MULT -> busy=0, hi=lo=0, result=0 immediately; a fresh MULT 6x7 afterwards -> lo=42, hi=0.
- With EXEC_UNIT_MULTU_EN: MULTU 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE; without the macro, the same instFunc with ALUOperation=010 performs ADD (result 1).
